// File: rtl/pipe_stall_sched.sv
// Stall/flush scheduler for the 5-stage pipeline: merges load-use, MUL/DIV occupancy,
// data-memory wait and branch redirects into per-stage controls, plus saturating counters.
module pipe_stall_sched #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 34,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_stall_req,
  input  logic             branch_taken_D,
  input  logic             mdu_op_E,
  input  logic             mdu_is_div_E,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic             redirect_ok,
  output logic             mdu_start,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned CW = $clog2(DIV_LAT);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          memstall, mdustall, cnt_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state, MDU sequencing and priority stall/flush decode.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    StallF      = 1'b0;
    StallD      = 1'b0;
    StallE      = 1'b0;
    StallM      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    FlushW      = 1'b0;
    redirect_ok = 1'b0;
    mdu_start   = 1'b0;
    mdu_done    = 1'b0;
    memstall    = dmem_req_M & ~dmem_ready;
    cnt_zero    = (cnt == '0);
    mdustall    = ((state == S_RUN)  & mdu_op_E)
                | ((state == S_WAIT) & ~cnt_zero)
                | ((state == S_HOLD) & memstall)
                | ((state == S_WAIT) & cnt_zero & memstall);

    case (state)
      S_RUN: begin
        if (mdu_op_E) begin
          mdu_start = 1'b1;
          cnt_nx    = mdu_is_div_E ? CW'(DIV_LAT - 2) : CW'(MUL_LAT - 2);
          state_nx  = S_WAIT;
        end
      end
      S_WAIT: begin
        // The unit keeps computing through a memory wait, so the count never pauses.
        if (!cnt_zero) begin
          cnt_nx = cnt - CW'(1);
        end else if (memstall) begin
          state_nx = S_HOLD;
        end else begin
          mdu_done = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_HOLD: begin
        if (!memstall) begin
          mdu_done = 1'b1;
          state_nx = S_RUN;
        end
      end
      default: state_nx = S_RUN;
    endcase

    if (memstall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (mdustall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (hz_stall_req) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end

    // A branch seen while D is held re-resolves once D advances.
    FlushD      = branch_taken_D & ~StallD;
    redirect_ok = FlushD;

    if (!rst_n) begin
      StallF      = 1'b0;
      StallD      = 1'b0;
      StallE      = 1'b0;
      StallM      = 1'b0;
      FlushD      = 1'b0;
      FlushE      = 1'b0;
      FlushM      = 1'b0;
      FlushW      = 1'b0;
      redirect_ok = 1'b0;
      mdu_start   = 1'b0;
      mdu_done    = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (StallF && (stall_cycles != {CNT_W{1'b1}}))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (FlushD && (flush_events != {CNT_W{1'b1}}))
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule
